pe_depacketizer: RTL and testbench

Clocked front end of the PE that sits directly upstream of the three-way input split. It accepts addressed packets from the PE's network port, discards packets not addressed to this PE or carrying an illegal type, and presents the surviving payload and its 2-bit route select to the split as two independent valid/ready channels. A small FIFO decouples network arrival from the split's consumption, and a saturating counter records dropped packets.

---
 rtl/pe_depacketizer.sv | 148 ++++++++++++++
 tb/tb_pe_depacketizer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pe_depacketizer.sv
// Network-side front end of the PE: filters addressed packets and feeds the
// surviving payload and route select to the split through a small FIFO.
module pe_depacketizer #(
    parameter int FILTER_WIDTH = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int PE_ADDR      = 0,
    parameter int DEPTH        = 2,
    localparam int PKT_WIDTH   = ADDR_WIDTH + 2 + 3 * FILTER_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PKT_WIDTH-1:0]      in_packet,
    output logic                      l_valid,
    input  logic                      l_ready,
    output logic [3*FILTER_WIDTH-1:0] l_data,
    output logic                      s_valid,
    input  logic                      s_ready,
    output logic [1:0]                s_sel,
    output logic [7:0]                drop_count
);

    localparam int PAYW    = 3 * FILTER_WIDTH;
    localparam int ENTRY_W = PAYW + 2;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, rd_inc_s;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               l_done_q, l_done_d;
    logic               s_done_q, s_done_d;
    logic [7:0]         drop_q, drop_d;
    logic [ENTRY_W-1:0] head_q, head_d;
    logic               l_valid_q, s_valid_q, in_ready_q;

    logic [ADDR_WIDTH-1:0] pkt_addr_s;
    logic [1:0]            pkt_type_s;
    logic [ENTRY_W-1:0]    pkt_entry_s;
    logic                  accept_s, keep_s, drop_s;
    logic                  l_fire_s, s_fire_s, pop_s;

    assign pkt_addr_s  = in_packet[PKT_WIDTH-1 -: ADDR_WIDTH];
    assign pkt_type_s  = in_packet[PAYW+1:PAYW];
    assign pkt_entry_s = in_packet[ENTRY_W-1:0];
    assign rd_inc_s    = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};

    // Handshake decode, classification and next-state computation.
    always_comb begin
        accept_s = in_valid && in_ready_q;
        keep_s   = accept_s && (pkt_addr_s == ADDR_WIDTH'(PE_ADDR)) && (pkt_type_s != 2'b11);
        drop_s   = accept_s && !keep_s;
        l_fire_s = l_valid_q && l_ready;
        s_fire_s = s_valid_q && s_ready;
        // A pop needs both halves of the head delivered, this cycle or earlier.
        pop_s    = (count_q != {CNT_W{1'b0}}) && (l_done_q || l_fire_s) && (s_done_q || s_fire_s);

        wr_ptr_d = keep_s ? wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1} : wr_ptr_q;
        rd_ptr_d = pop_s ? rd_inc_s : rd_ptr_q;

        if (keep_s && !pop_s) begin
            count_d = count_q + {{PTR_W{1'b0}}, 1'b1};
        end else if (pop_s && !keep_s) begin
            count_d = count_q - {{PTR_W{1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end

        if (pop_s) begin
            l_done_d = 1'b0;
            s_done_d = 1'b0;
        end else begin
            l_done_d = l_done_q || l_fire_s;
            s_done_d = s_done_q || s_fire_s;
        end

        if (drop_s && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end

        // Head register follows the entry that will sit at the read pointer.
        if (pop_s) begin
            if (count_q > CNT_W'(1)) begin
                head_d = mem_q[rd_inc_s];
            end else if (keep_s) begin
                head_d = pkt_entry_s;
            end else begin
                head_d = head_q;
            end
        end else if (keep_s && (count_q == {CNT_W{1'b0}})) begin
            head_d = pkt_entry_s;
        end else begin
            head_d = head_q;
        end
    end

    // Control, counter and registered output state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            l_done_q   <= 1'b0;
            s_done_q   <= 1'b0;
            drop_q     <= 8'd0;
            head_q     <= {ENTRY_W{1'b0}};
            l_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            l_done_q   <= l_done_d;
            s_done_q   <= s_done_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
            l_valid_q  <= (count_d != {CNT_W{1'b0}}) && !l_done_d;
            s_valid_q  <= (count_d != {CNT_W{1'b0}}) && !s_done_d;
            in_ready_q <= (count_d != CNT_W'(DEPTH));
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {ENTRY_W{1'b0}};
            end
        end else if (keep_s) begin
            mem_q[wr_ptr_q] <= pkt_entry_s;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign in_ready   = in_ready_q;
    assign l_valid    = l_valid_q;
    assign s_valid    = s_valid_q;
    assign l_data     = head_q[PAYW-1:0];
    assign s_sel      = head_q[ENTRY_W-1:PAYW];
    assign drop_count = drop_q;

endmodule

// File: tb/tb_pe_depacketizer.sv
// Bench for pe_depacketizer: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-based reference model.
module tb_pe_depacketizer;

    localparam int D  = 2;
    localparam int PW = 30;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [PW-1:0] in_packet;
    logic          l_valid, l_ready, s_valid, s_ready;
    logic [23:0]   l_data;
    logic [1:0]    s_sel;
    logic [7:0]    drop_count;

    int errors = 0;
    int checks = 0;

    logic [25:0] mq[$];
    bit          m_l, m_s;
    int          m_drop;

    pe_depacketizer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_packet(in_packet),
        .l_valid(l_valid), .l_ready(l_ready), .l_data(l_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_sel(s_sel),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] pk(input logic [3:0] a, input logic [1:0] t, input logic [23:0] p);
        return {a, t, p};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_l = 1'b0;
        m_s = 1'b0;
        m_drop = 0;
    endtask

    // One clock: compare outputs against the model, drive inputs, advance the model.
    task automatic cycle(input logic v, input logic [PW-1:0] p, input logic lr, input logic sr);
        bit acc, lf, sf;
        @(negedge clk);
        check("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < D});
        check("l_valid", {31'd0, l_valid}, {31'd0, mq.size() > 0 && !m_l});
        check("s_valid", {31'd0, s_valid}, {31'd0, mq.size() > 0 && !m_s});
        check("drop_count", {24'd0, drop_count}, m_drop);
        if (mq.size() > 0) begin
            check("l_data", {8'd0, l_data}, {8'd0, mq[0][23:0]});
            check("s_sel", {30'd0, s_sel}, {30'd0, mq[0][25:24]});
        end
        in_valid = v; in_packet = p; l_ready = lr; s_ready = sr;
        @(posedge clk);
        acc = v && (mq.size() < D);
        lf  = (mq.size() > 0) && !m_l && lr;
        sf  = (mq.size() > 0) && !m_s && sr;
        if ((mq.size() > 0) && (m_l || lf) && (m_s || sf)) begin
            void'(mq.pop_front());
            m_l = 1'b0;
            m_s = 1'b0;
        end else begin
            m_l = m_l || lf;
            m_s = m_s || sf;
        end
        if (acc) begin
            if (p[29:26] == 4'd0 && p[25:24] != 2'b11) mq.push_back(p[25:0]);
            else if (m_drop < 255) m_drop++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, {PW{1'b0}}, 1'b1, 1'b1);
    endtask

    initial begin
        logic [3:0] ra;
        rst_n = 1'b0; in_valid = 1'b0; in_packet = '0; l_ready = 1'b0; s_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_l_valid", {31'd0, l_valid}, 32'd0);
        check("rst_s_valid", {31'd0, s_valid}, 32'd0);
        check("rst_l_data", {8'd0, l_data}, 32'd0);
        check("rst_s_sel", {30'd0, s_sel}, 32'd0);
        check("rst_drop", {24'd0, drop_count}, 32'd0);
        rst_n = 1'b1;

        // Routing, one per cycle with consumers always ready.
        cycle(1'b1, pk(4'd0, 2'd0, 24'h111111), 1'b1, 1'b1);
        cycle(1'b1, pk(4'd0, 2'd1, 24'h222222), 1'b1, 1'b1);
        cycle(1'b1, pk(4'd0, 2'd2, 24'h333333), 1'b1, 1'b1);
        idle(3);

        // Filtering.
        cycle(1'b1, pk(4'd5, 2'd0, 24'h555555), 1'b1, 1'b1);
        cycle(1'b1, pk(4'd0, 2'd3, 24'h666666), 1'b1, 1'b1);
        cycle(1'b1, pk(4'd0, 2'd1, 24'hABCDEF), 1'b1, 1'b1);
        idle(2);
        check("filter_drop", {24'd0, drop_count}, 32'd2);

        // Skewed consumers: select side stalls for 4 cycles.
        cycle(1'b1, pk(4'd0, 2'd2, 24'h0A0A0A), 1'b1, 1'b0);
        cycle(1'b1, pk(4'd0, 2'd0, 24'h0B0B0B), 1'b1, 1'b0);
        cycle(1'b0, {PW{1'b0}}, 1'b1, 1'b0);
        cycle(1'b0, {PW{1'b0}}, 1'b1, 1'b0);
        idle(4);

        // Backpressure: full FIFO refuses the third packet until a pop.
        cycle(1'b1, pk(4'd0, 2'd0, 24'hC00001), 1'b0, 1'b0);
        cycle(1'b1, pk(4'd0, 2'd1, 24'hC00002), 1'b0, 1'b0);
        cycle(1'b1, pk(4'd0, 2'd2, 24'hC00003), 1'b0, 1'b0);
        cycle(1'b1, pk(4'd0, 2'd2, 24'hC00003), 1'b1, 1'b1);
        cycle(1'b1, pk(4'd0, 2'd2, 24'hC00003), 1'b1, 1'b1);
        idle(4);

        // Asynchronous reset with two entries held and a nonzero drop count.
        cycle(1'b1, pk(4'd9, 2'd0, 24'h000000), 1'b0, 1'b0);
        cycle(1'b1, pk(4'd0, 2'd1, 24'hD00001), 1'b1, 1'b0);
        cycle(1'b1, pk(4'd0, 2'd2, 24'hD00002), 1'b0, 1'b0);
        cycle(1'b0, {PW{1'b0}}, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_l_valid", {31'd0, l_valid}, 32'd0);
        check("midrst_s_valid", {31'd0, s_valid}, 32'd0);
        check("midrst_drop", {24'd0, drop_count}, 32'd0);
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        idle(2);

        // Saturation of the drop counter.
        for (int i = 0; i < 260; i++)
            cycle(1'b1, pk(4'd7, 2'($urandom_range(3)), 24'($urandom)), 1'($urandom), 1'($urandom));
        idle(1);
        check("sat_drop", {24'd0, drop_count}, 32'd255);
        check("sat_empty", {31'd0, l_valid}, 32'd0);

        // Random traffic after a clean reset.
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            ra = ($urandom_range(3) == 0) ? 4'($urandom) : 4'd0;
            cycle(1'($urandom), pk(ra, 2'($urandom_range(3)), 24'($urandom)),
                  ($urandom_range(3) != 0), ($urandom_range(3) != 0));
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
